// File: rtl/run_matcher_pkg.sv
// Shared types and default widths for the run_matcher symbol-run detector.
package run_matcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    MATCH = 2'b10,
    ERROR = 2'b11
  } state_t;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_HIT_W = 8;

endpackage

// File: rtl/run_matcher_run_counter.sv
// Saturating run-length register with synchronous clear/increment and a
// look-ahead compare telling the FSM whether one more hit reaches thr.
module run_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_thr
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      // clear together with inc restarts a run at length 1
      cnt_reg <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign at_thr = (({1'b0, cnt_reg} + (CNT_W + 1)'(1)) >= {1'b0, thr});

endmodule

// File: rtl/run_matcher.sv
// Detects runs of match_sym in a valid-qualified symbol stream.
// Optional hit counter enabled by defining RUN_MATCHER_HITCNT_EN.
module run_matcher
  import run_matcher_pkg::*;
#(
  parameter int SYM_W = 1,
  parameter int CNT_W = DEF_CNT_W,
  parameter int HIT_W = DEF_HIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  input  logic [SYM_W-1:0] match_sym,
  input  logic [CNT_W-1:0] threshold,
  output logic             y_val,
  output logic             match_pulse,
  output logic [CNT_W-1:0] run_len,
  output logic [HIT_W-1:0] hit_cnt,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] thr_reg, thr_next;
  logic             pulse_reg;
  logic             enter_match;
  logic             cnt_clear, cnt_inc, at_thr;
  logic [CNT_W-1:0] cnt;
  logic             hit, miss;
  logic [CNT_W-1:0] thr_eff;

  assign hit     = in_valid && (in_sym == match_sym);
  assign miss    = in_valid && (in_sym != match_sym);
  assign thr_eff = (threshold == '0) ? CNT_W'(1) : threshold;

  always_comb begin
    state_next  = state_reg;
    thr_next    = thr_reg;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    enter_match = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && hit) begin
          thr_next  = thr_eff;
          cnt_clear = 1'b1;
          cnt_inc   = 1'b1;
          if (thr_eff == CNT_W'(1)) begin
            state_next  = MATCH;
            enter_match = 1'b1;
          end else begin
            state_next = COUNT;
          end
        end
      end
      COUNT: begin
        if (hit) begin
          cnt_inc = 1'b1;
          if (at_thr) begin
            state_next  = MATCH;
            enter_match = 1'b1;
          end
        end else if (miss) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end
      end
      MATCH: begin
        if (hit) begin
          cnt_inc = 1'b1;
        end else if (miss) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      thr_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      thr_reg   <= thr_next;
      pulse_reg <= enter_match;
    end
  end

  run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .thr    (thr_reg),
    .cnt    (cnt),
    .at_thr (at_thr)
  );

`ifdef RUN_MATCHER_HITCNT_EN
  logic [HIT_W-1:0] hit_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_reg <= '0;
    end else if (enter_match) begin
      hit_cnt_reg <= hit_cnt_reg + HIT_W'(1);
    end
  end

  assign hit_cnt = hit_cnt_reg;
`else
  assign hit_cnt = '0;
`endif

  // Outputs decode from registers only; an illegal state forces them quiet.
  assign y_val       = (state_reg == MATCH);
  assign busy        = (state_reg == COUNT) || (state_reg == MATCH);
  assign match_pulse = pulse_reg && (state_reg != ERROR);
  assign run_len     = (state_reg == ERROR) ? '0 : cnt;

endmodule

// File: tb/tb_run_matcher.sv
// Scoreboard bench for run_matcher (SYM_W=4, CNT_W=3) with a run-length reference model.
module tb_run_matcher;

  localparam int SYM_W = 4;
  localparam int CNT_W = 3;
  localparam int HIT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, in_valid;
  logic [SYM_W-1:0] in_sym, match_sym;
  logic [CNT_W-1:0] threshold;
  logic             y_val, match_pulse, busy;
  logic [CNT_W-1:0] run_len;
  logic [HIT_W-1:0] hit_cnt;

  typedef struct {
    logic             y;
    logic             p;
    logic             b;
    logic [CNT_W-1:0] rl;
    logic [HIT_W-1:0] hc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state: run length kept unbounded, saturation applied on output
  bit   m_active = 0;
  int   m_run    = 0;
  int   m_thr    = 0;
  int   m_hits   = 0;
  bit   m_pulse  = 0;

  run_matcher #(.SYM_W(SYM_W), .CNT_W(CNT_W), .HIT_W(HIT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .match_sym   (match_sym),
    .threshold   (threshold),
    .y_val       (y_val),
    .match_pulse (match_pulse),
    .run_len     (run_len),
    .hit_cnt     (hit_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit st, input bit v,
                              input int sym, input int msym, input int thr);
    m_pulse = 0;
    if (rst) begin
      m_active = 0; m_run = 0; m_thr = 0; m_hits = 0;
    end else if (v) begin
      if (sym == msym) begin
        if (!m_active) begin
          if (st) begin
            m_active = 1;
            m_thr    = (thr == 0) ? 1 : thr;
            m_run    = 1;
            m_pulse  = (m_run == m_thr);
          end
        end else begin
          m_run++;
          m_pulse = (m_run == m_thr);
        end
      end else begin
        m_active = 0;
        m_run    = 0;
      end
    end
    if (m_pulse) m_hits++;
  endtask

  // drive one cycle at the negedge and queue what the next posedge must produce
  task automatic step(input bit rst, input bit st, input bit v,
                      input int sym, input int msym, input int thr);
    exp_t e;
    reset     = rst;
    start     = st;
    in_valid  = v;
    in_sym    = SYM_W'(sym);
    match_sym = SYM_W'(msym);
    threshold = CNT_W'(thr);
    model_update(rst, st, v, sym, msym, thr);
    e.y  = m_active && (m_run >= m_thr);
    e.p  = m_pulse;
    e.b  = m_active;
    e.rl = CNT_W'((m_run > SAT) ? SAT : m_run);
`ifdef RUN_MATCHER_HITCNT_EN
    e.hc = HIT_W'(m_hits);
`else
    e.hc = '0;
`endif
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("y_val",       int'(y_val),       int'(e.y));
        chk("match_pulse", int'(match_pulse), int'(e.p));
        chk("busy",        int'(busy),        int'(e.b));
        chk("run_len",     int'(run_len),     int'(e.rl));
        chk("hit_cnt",     int'(hit_cnt),     int'(e.hc));
        $display("cyc t=%0t rst=%0b st=%0b v=%0b sym=%h y=%0b p=%0b b=%0b rl=%0d hc=%0d",
                 $time, reset, start, in_valid, in_sym, y_val, match_pulse, busy,
                 run_len, hit_cnt);
      end
    end
  end

  initial begin : driver
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_sym = '0; match_sym = '0; threshold = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 10, 4);
    step(1, 0, 0, 0, 10, 4);

    // basic detect: threshold 4, five hits then a miss
    for (int i = 0; i < 5; i++) step(0, 1, 1, 10, 10, 4);
    step(0, 1, 1, 11, 10, 4);
    step(0, 0, 1, 11, 10, 4);

    // same stream with stalls interleaved
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 10, 10, 4);
      step(0, 1, 0, 11, 10, 4);
    end
    step(0, 1, 0, 11, 10, 4);
    step(0, 1, 1, 11, 10, 4);

    // threshold 0 acts as 1; later threshold changes are ignored
    step(0, 1, 1, 10, 10, 0);
    step(0, 1, 1, 10, 10, 7);
    step(0, 1, 1, 10, 10, 7);
    step(0, 1, 1, 3, 10, 7);
    // miss in MATCH then an immediate new run
    step(0, 1, 1, 10, 10, 2);
    step(0, 1, 1, 10, 10, 2);
    step(0, 1, 1, 3, 10, 2);
    step(0, 1, 1, 10, 10, 2);
    // a miss never starts a run; a hit without start is ignored in IDLE
    step(0, 1, 1, 3, 10, 2);
    step(0, 0, 1, 10, 10, 2);
    step(0, 1, 1, 3, 10, 2);

    // saturation: ten hits with threshold 2, then a different symbol
    for (int i = 0; i < 10; i++) step(0, 1, 1, 10, 10, 2);
    step(0, 1, 1, 11, 10, 2);

    // reset mid-MATCH with run_len at 6
    for (int i = 0; i < 6; i++) step(0, 1, 1, 10, 10, 3);
    step(1, 1, 1, 10, 10, 3);
    step(0, 0, 0, 0, 10, 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int msym, sym;
      msym = ($urandom_range(0, 1) == 0) ? 10 : 5;
      sym  = ($urandom_range(0, 4) != 0) ? msym : int'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) < 17), sym, msym, int'($urandom_range(0, 7)));
    end

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
